fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the PC, issues in-order requests to instruction memory over a valid/ready handshake, buffers returned words in a small prefetch FIFO and drives the IF/ID pipeline register consumed by the decode stage. It honours the hazard unit's data stall and redirects on branches/jumps resolved in decode. Sits directly upstream of the datapath's decode stage.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries (≥2); also the bound on outstanding requests plus buffered words

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, in request order, never back-pressured
- imem_rsp_data  in  32  instruction word
- stall_d  in  1  hazard-unit data stall; hold IF/ID
- redirect  in  1  branch/jump taken in decode
- redirect_pc  in  32  target address
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- valid_d  out  1  IF/ID holds a real instruction

## Operation
- State: fetch_pc, FIFO of {pc, instr}, outstanding count, discard count, IF/ID register.
- Request: imem_req_valid = 1 when outstanding + FIFO occupancy < FIFO_DEPTH; imem_req_addr = fetch_pc. On accept (valid & ready) fetch_pc += 4, outstanding += 1.
- Response: if discard > 0, word dropped, discard −= 1; otherwise pushed to FIFO tagged with its PC (tracked by a response-PC register). Outstanding −= 1 in both cases.
- IF/ID load when stall_d = 0: FIFO head if non-empty; else bypass of a same-cycle non-discarded response; else bubble (instr_d = 0 i.e. nop, valid_d = 0, pc_d unchanged). stall_d = 1: IF/ID, FIFO pops frozen; requests and pushes continue within capacity.
- redirect qualified by !stall_d; ignored while stall_d = 1.
- Redirect: fetch_pc ← redirect_pc; response-PC ← redirect_pc; discard ← outstanding not retained; FIFO flushed except entries retained by configuration; a request accepted the same cycle is counted as discarded.
- Arithmetic: PC adds modulo 2^32; redirect_pc[1:0] ignored (forced 0).

## Timing
- During reset: imem_req_valid 0, imem_req_addr RESET_PC, instr_d 0, pc_d RESET_PC, valid_d 0, FIFO empty, counters 0.
- First request in the first cycle after reset deasserts, address RESET_PC.
- Zero-wait memory (ready = 1, response cycle after accept): request accepted edge n, instr_d valid after edge n+1; sustained 1 instruction/cycle.
- FIFO full with stall_d = 1: imem_req_valid drops the same cycle capacity is reached; no word lost.
- Simultaneous push and pop: occupancy unchanged.
- Reset mid-operation clears all state immediately; instruction memory shares the reset, so no pre-reset response arrives afterwards.

## Configuration
- FETCH_DELAY_SLOT_EN defined: on redirect the single next-in-order instruction after pc_d (FIFO head, bypass response, or oldest in-flight response) is retained and loads IF/ID as the delay slot; all younger entries discarded.
- Undefined: no delay slot; IF/ID becomes a bubble on redirect, whole FIFO flushed, all outstanding responses discarded.

## Structure
- Shared package mips_pkg: NOP_INSTR constant, RESET_PC default, fetch-entry typedef {pc, instr}.
- One sub-module: fetch_fifo (parameterised depth, push/pop/flush, keep-head option for delay-slot retention).

## Test plan
- Reset release, ready = 1, 1-cycle memory -> requests 0x3000, 0x3004, 0x3008 on consecutive cycles; instr_d/pc_d step each cycle from 2 cycles after release.
- stall_d held 4 cycles -> instr_d/pc_d constant; at most FIFO_DEPTH requests beyond IF/ID, then imem_req_valid = 0; no word lost on release.
- redirect to 0x3100 with pc_d = 0x3010, no macro -> next valid_d = 1 shows pc_d 0x3100; words for 0x3014+ never reach IF/ID.
- Same with FETCH_DELAY_SLOT_EN -> pc_d 0x3014 then 0x3100.
- redirect with stall_d = 1 -> ignored; fetch continues sequentially.
- Reset asserted with 2 requests outstanding -> outputs return to reset values immediately; fetch restarts at 0x3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: reset vector, NOP encoding,
// and the {pc, instr} entry carried through the fetch prefetch buffer.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {pc, instr} entries with push/pop/flush; flush can
// optionally keep the current head when that head is not popped the same cycle.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  fetch_entry_t       push_entry_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic               keep_head_i,
    output fetch_entry_t       head_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            if (keep_head_i && (count_q != '0) && !do_pop) begin
                wr_ptr_d = next_ptr(rd_ptr_q);
                count_d  = CNT_W'(1);
            end else begin
                rd_ptr_d = wr_ptr_q;
                count_d  = '0;
            end
        end else begin
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, in-order imem requests, prefetch FIFO, IF/ID register.
// Define FETCH_DELAY_SLOT_EN to retain the next in-order instruction as a branch delay slot.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d
);

    localparam int             CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CAP   = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic             if_valid_q, if_valid_d;

    fetch_entry_t     fifo_head, rsp_entry;
    logic             fifo_empty, fifo_push, fifo_pop, fifo_keep;
    logic [CNT_W-1:0] fifo_count;
    logic             req_fire, rsp_keep, rsp_drop, load_if, redirect_act, bypass;
    logic [31:0]      target;

    assign imem_req_valid = reset && (({1'b0, outst_q} + {1'b0, fifo_count}) < CAP);
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign rsp_keep     = imem_rsp_valid && (discard_q == '0);
    assign rsp_drop     = imem_rsp_valid && (discard_q != '0);
    assign load_if      = !stall_d;
    assign redirect_act = redirect && !stall_d;
    assign target       = word_align(redirect_pc);
    assign fifo_pop     = load_if && !fifo_empty;
    assign bypass       = load_if && fifo_empty && rsp_keep;
    assign fifo_push    = rsp_keep && !bypass && !redirect_act;
    assign rsp_entry    = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign outst_d      = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

`ifdef FETCH_DELAY_SLOT_EN
    // A pending slot is a retained word still in flight (or not yet requested);
    // once it lands, the response PC jumps to the saved target and the tail is dropped.
    logic             slot_pend_q, slot_pend_d;
    logic             slot_req_q, slot_req_d;
    logic [CNT_W-1:0] slot_tail_q, slot_tail_d;
    logic [31:0]      slot_tgt_q, slot_tgt_d;

    assign fifo_keep = 1'b1;
`else
    assign fifo_keep = 1'b0;
`endif

    always_comb begin
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        discard_d  = rsp_drop ? discard_q - CNT_W'(1) : discard_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        if (load_if) begin
            if (!fifo_empty) begin
                if_instr_d = fifo_head.instr;
                if_pc_d    = fifo_head.pc;
                if_valid_d = 1'b1;
            end else if (rsp_keep) begin
                if_instr_d = imem_rsp_data;
                if_pc_d    = rsp_pc_q;
                if_valid_d = 1'b1;
            end else begin
                if_instr_d = NOP_INSTR;
                if_valid_d = 1'b0;
            end
        end

`ifdef FETCH_DELAY_SLOT_EN
        slot_pend_d = slot_pend_q;
        slot_req_d  = slot_req_q;
        slot_tail_d = slot_tail_q;
        slot_tgt_d  = slot_tgt_q;

        if (req_fire && slot_req_q) begin
            fetch_pc_d = slot_tgt_q;
            slot_req_d = 1'b0;
        end
        if (rsp_keep && slot_pend_q) begin
            rsp_pc_d    = slot_tgt_q;
            discard_d   = slot_tail_q;
            slot_pend_d = 1'b0;
        end

        if (redirect_act) begin
            if (!fifo_empty || rsp_keep) begin
                // Slot word goes straight into IF/ID this cycle.
                fetch_pc_d  = target;
                rsp_pc_d    = target;
                discard_d   = outst_d;
                slot_pend_d = 1'b0;
                slot_req_d  = 1'b0;
            end else begin
                slot_pend_d = 1'b1;
                slot_tgt_d  = target;
                if (outst_d != discard_d) begin
                    fetch_pc_d  = target;
                    slot_tail_d = outst_d - discard_d - CNT_W'(1);
                    slot_req_d  = 1'b0;
                end else begin
                    fetch_pc_d  = fetch_pc_q;
                    slot_tail_d = '0;
                    slot_req_d  = 1'b1;
                end
            end
        end
`else
        if (redirect_act) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            discard_d  = outst_d;
            if_instr_d = NOP_INSTR;
            if_pc_d    = if_pc_q;
            if_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= RESET_PC;
            if_valid_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_pend_q <= 1'b0;
            slot_req_q  <= 1'b0;
            slot_tail_q <= '0;
            slot_tgt_q  <= RESET_PC;
        end else begin
            slot_pend_q <= slot_pend_d;
            slot_req_q  <= slot_req_d;
            slot_tail_q <= slot_tail_d;
            slot_tgt_q  <= slot_tgt_d;
        end
    end
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (fifo_push),
        .push_entry_i (rsp_entry),
        .pop_i        (fifo_pop),
        .flush_i      (redirect_act),
        .keep_head_i  (fifo_keep),
        .head_o       (fifo_head),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    assign instr_d = if_instr_q;
    assign pc_d    = if_pc_q;
    assign valid_d = if_valid_q;

endmodule
